// File: rtl/mmio_mailbox.sv
// rtl/mmio_mailbox.sv - MMIO register window bridging CPU loads/stores to TX/RX stream FIFOs
// Optional interrupt output and enable bit are built when MMIO_MAILBOX_IRQ_EN is defined.
module mmio_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrt,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        hit,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
`ifdef MMIO_MAILBOX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   tx_mem [DEPTH];
  logic [31:0]   rx_mem [DEPTH];
  logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [AW:0]   tx_cnt, rx_cnt, tx_cnt_next, rx_cnt_next;
  logic          ovf;
  logic [1:0]    sel;
  logic          wr, data_wr, ctrl_wr, flush;
  logic          tx_full, tx_pop, tx_push;
  logic          rx_full, rx_empty, rx_pop, rx_push;
  logic [31:0]   ctrl_rd;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = &{1'b0, addr[1:0]};

  assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel     = addr[3:2];
  assign wr      = memwrt & hit;
  assign data_wr = wr & (sel == 2'd0);
  assign ctrl_wr = wr & (sel == 2'd2);
  assign flush   = ctrl_wr & writedata[1];

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_valid = (tx_cnt != '0);
  assign tx_pop   = tx_valid & tx_ready;
  // A store into a full TX FIFO still lands if the head leaves in the same cycle.
  assign tx_push  = data_wr & (~tx_full | tx_pop);
  assign tx_data  = tx_valid ? tx_mem[tx_rd] : 32'h0;

  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);
  assign rx_pop   = ctrl_wr & writedata[0] & ~rx_empty;
  assign rx_ready = ~flush & (~rx_full | rx_pop);
  assign rx_push  = rx_valid & rx_ready;

  always_comb begin
    tx_cnt_next = tx_cnt;
    rx_cnt_next = rx_cnt;
    if (flush) begin
      tx_cnt_next = '0;
      rx_cnt_next = '0;
    end else begin
      if (tx_push & ~tx_pop) tx_cnt_next = tx_cnt + (AW+1)'(1);
      else if (~tx_push & tx_pop) tx_cnt_next = tx_cnt - (AW+1)'(1);
      if (rx_push & ~rx_pop) rx_cnt_next = rx_cnt + (AW+1)'(1);
      else if (~rx_push & rx_pop) rx_cnt_next = rx_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      rx_wr  <= '0;
      rx_rd  <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      ovf    <= 1'b0;
    end else begin
      tx_cnt <= tx_cnt_next;
      rx_cnt <= rx_cnt_next;
      if (flush) begin
        tx_wr <= '0;
        tx_rd <= '0;
        rx_wr <= '0;
        rx_rd <= '0;
      end else begin
        if (tx_push) tx_wr <= tx_wr + AW'(1);
        if (tx_pop)  tx_rd <= tx_rd + AW'(1);
        if (rx_push) rx_wr <= rx_wr + AW'(1);
        if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      end
      if (ctrl_wr & writedata[2]) ovf <= 1'b0;
      else if (data_wr & tx_full & ~tx_pop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= writedata;
    if (rx_push) rx_mem[rx_wr] <= rx_data;
  end

`ifdef MMIO_MAILBOX_IRQ_EN
  logic ien;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ien <= 1'b0;
      irq <= 1'b0;
    end else begin
      irq <= ien & (rx_cnt_next != '0);
      if (ctrl_wr) ien <= writedata[3];
    end
  end

  assign ctrl_rd = {29'h0, ien, 2'b00};
`else
  assign ctrl_rd = 32'h0;
`endif

  always_comb begin
    readdata = 32'h0;
    if (hit) begin
      case (sel)
        2'd0:    readdata = rx_empty ? 32'h0 : rx_mem[rx_rd];
        2'd1:    readdata = {8'h0, 8'(rx_cnt), 8'(tx_cnt), 5'h0, ovf, tx_full, rx_empty};
        2'd2:    readdata = ctrl_rd;
        default: readdata = 32'h0;
      endcase
    end
  end

endmodule
